// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / ertn commit controller with the exception CSR block.
// Accepts an exception or ertn from WB in IDLE, updates the CSRs on that same
// edge, pulses flush for one cycle, then holds a redirect to preIF until the
// handshake completes.
//
// Optional feature: define TIMER_INT_EN to build the timer CSRs (TCFG, TVAL,
// TICLR) and drive ESTAT.IS[11] from the timer. When it is not defined, the
// timer CSRs read 0, writes to them are dropped, and IS[11] is constant 0.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   wb_ex, wb_ecode, wb_esubcode exception commit and its codes
//   wb_pc, wb_vaddr             faulting PC and data address
//   ertn_flush                  ertn commit
//   csr_num/we/wmask/wdata      CSR access port
//   csr_rvalue                  combinational read of csr_num (pre-write value)
//   has_int                     enabled interrupt pending (combinational)
//   flush                       one-cycle pipeline flush strobe (registered)
//   redir_valid/pc, redir_ready redirect handshake to preIF (registered)
module exc_ctrl #(
  parameter logic [31:0] EENTRY_RST = 32'h1C00_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rvalue,
  output logic        has_int,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned LIE_W   = 13;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned ESUB_W  = 9;
  localparam int unsigned EENT_W  = 26;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
`ifdef TIMER_INT_EN
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;
`endif

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept_ex, accept_ertn;

  // CSR state
  logic [1:0]         crmd_plv;
  logic               crmd_ie;
  logic [1:0]         prmd_pplv;
  logic               prmd_ppie;
  logic [LIE_W-1:0]   ecfg_lie;
  logic [1:0]         estat_is_sw;
  logic [ECODE_W-1:0] estat_ecode;
  logic [ESUB_W-1:0]  estat_esub;
  logic [XLEN-1:0]    era;
  logic [XLEN-1:0]    badv;
  logic [EENT_W-1:0]  eentry;
  logic               timer_is;

  logic [LIE_W-1:0]   estat_is;
  logic               csr_wr;
  logic [XLEN-1:0]    csr_merge;

`ifdef TIMER_INT_EN
  logic [XLEN-1:0]    tcfg;
  logic [XLEN-1:0]    tval;
  logic               timer_fire;
  logic               tcfg_wr;
  logic               ticlr_clr;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state; exception takes priority over ertn, both ignored outside IDLE
  always_comb begin
    state_nxt   = state;
    accept_ex   = 1'b0;
    accept_ertn = 1'b0;
    case (state)
      S_IDLE: begin
        if (wb_ex) begin
          accept_ex = 1'b1;
          state_nxt = S_FLUSH;
        end else if (ertn_flush) begin
          accept_ertn = 1'b1;
          state_nxt   = S_FLUSH;
        end
      end
      S_FLUSH: state_nxt = S_REDIR;
      S_REDIR: if (redir_valid && redir_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      flush       <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      flush       <= (state_nxt == S_FLUSH);
      redir_valid <= (state_nxt == S_REDIR);
      if (accept_ex)        redir_pc <= {eentry, 6'd0};
      else if (accept_ertn) redir_pc <= era;
    end
  end

  assign estat_is = {1'b0, timer_is, 9'd0, estat_is_sw};

  // CSR read mux; unimplemented numbers and TICLR read 0
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {29'd0, crmd_ie, crmd_plv};
      CSR_PRMD:   csr_rvalue = {29'd0, prmd_ppie, prmd_pplv};
      CSR_ECFG:   csr_rvalue = {19'd0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub, estat_ecode, 3'd0, estat_is};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry, 6'd0};
`ifdef TIMER_INT_EN
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = tval;
`endif
      default:    csr_rvalue = '0;
    endcase
  end

  // Software write is dropped when a commit is accepted in the same cycle
  assign csr_wr    = csr_we && !(accept_ex || accept_ertn);
  assign csr_merge = (csr_rvalue & ~csr_wmask) | (csr_wdata & csr_wmask);

  assign has_int = crmd_ie && (|(estat_is & ecfg_lie));

  // Exception CSRs: commit updates first, otherwise software writes
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      prmd_pplv   <= '0;
      prmd_ppie   <= 1'b0;
      ecfg_lie    <= '0;
      estat_is_sw <= '0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era         <= '0;
      badv        <= '0;
      eentry      <= EENTRY_RST[31:6];
    end else if (accept_ex) begin
      prmd_pplv   <= crmd_plv;
      prmd_ppie   <= crmd_ie;
      crmd_plv    <= 2'd0;
      crmd_ie     <= 1'b0;
      era         <= wb_pc;
      estat_ecode <= wb_ecode;
      estat_esub  <= wb_esubcode;
      if (wb_ecode == ECODE_ADE || wb_ecode == ECODE_ALE) badv <= wb_vaddr;
    end else if (accept_ertn) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_ppie;
    end else if (csr_wr) begin
      case (csr_num)
        CSR_CRMD: begin
          crmd_plv <= csr_merge[1:0];
          crmd_ie  <= csr_merge[2];
        end
        CSR_PRMD: begin
          prmd_pplv <= csr_merge[1:0];
          prmd_ppie <= csr_merge[2];
        end
        CSR_ECFG:   ecfg_lie    <= csr_merge[LIE_W-1:0];
        CSR_ESTAT:  estat_is_sw <= csr_merge[1:0];
        CSR_ERA:    era         <= csr_merge;
        CSR_BADV:   badv        <= csr_merge;
        CSR_EENTRY: eentry      <= csr_merge[31:6];
        default: ;
      endcase
    end
  end

`ifdef TIMER_INT_EN
  assign tcfg_wr    = csr_wr && (csr_num == CSR_TCFG);
  assign ticlr_clr  = csr_wr && (csr_num == CSR_TICLR) && csr_merge[0];
  assign timer_fire = tcfg[0] && (tval == 32'd1);

  // Timer: TCFG write reloads TVAL; countdown, periodic reload, IS[11] set/clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg     <= '0;
      tval     <= '0;
      timer_is <= 1'b0;
    end else begin
      if (tcfg_wr) begin
        tcfg <= csr_merge;
        tval <= {csr_merge[31:2], 2'b00};
      end else if (tcfg[0]) begin
        if (tval != 32'd0) tval <= tval - 32'd1;
        else if (tcfg[1])  tval <= {tcfg[31:2], 2'b00};
      end
      // A timer expiry in the same cycle beats a TICLR clear
      if (timer_fire)     timer_is <= 1'b1;
      else if (ticlr_clr) timer_is <= 1'b0;
    end
  end
`else
  assign timer_is = 1'b0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rvalue;
  logic        has_int;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_UNIMP  = 14'h003;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  exc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .ertn_flush  (ertn_flush),
    .csr_num     (csr_num),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wdata   (csr_wdata),
    .csr_rvalue  (csr_rvalue),
    .has_int     (has_int),
    .flush       (flush),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_num = num;
    #1;
    check(tag, csr_rvalue, exp);
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] data);
    csr_num   = num;
    csr_wmask = mask;
    csr_wdata = data;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic raise_ex(input logic [5:0] ec, input logic [8:0] esub,
                          input logic [31:0] pc, input logic [31:0] va);
    wb_ex       = 1'b1;
    wb_ecode    = ec;
    wb_esubcode = esub;
    wb_pc       = pc;
    wb_vaddr    = va;
    tick();
    wb_ex       = 1'b0;
  endtask

  // Called in FLUSH: move to REDIR, then complete the handshake at once
  task automatic drain(input string tag);
    tick();
    check({tag, "_rv"}, 32'(redir_valid), 32'd1);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check({tag, "_idle"}, 32'(redir_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; wb_vaddr = '0; ertn_flush = 1'b0; csr_num = '0;
    csr_we = 1'b0; csr_wmask = '0; csr_wdata = '0; redir_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rv", 32'(redir_valid), 32'd0);
    check("rst_rpc", redir_pc, 32'd0);
    check_csr("rst_crmd", A_CRMD, 32'd0);
    check_csr("rst_estat", A_ESTAT, 32'd0);
    check_csr("rst_eentry", A_EENTRY, 32'h1C00_8000);
    check("rst_int", 32'(has_int), 32'd0);

    // Exception entry from PLV3 with IE set
    csr_write(A_CRMD, 32'h7, 32'h7);
    check_csr("crmd_w", A_CRMD, 32'h7);
    raise_ex(6'h0B, 9'h0, 32'h1C00_0100, 32'h0000_DEAD);
    check("ex_flush", 32'(flush), 32'd1);
    check("ex_rv0", 32'(redir_valid), 32'd0);
    check("ex_rpc", redir_pc, 32'h1C00_8000);
    check_csr("ex_era", A_ERA, 32'h1C00_0100);
    check_csr("ex_prmd", A_PRMD, 32'h7);
    check_csr("ex_crmd", A_CRMD, 32'h0);
    check_csr("ex_estat", A_ESTAT, 32'h000B_0000);
    check_csr("ex_badv0", A_BADV, 32'h0);
    tick();
    check("ex_flush_off", 32'(flush), 32'd0);
    check("ex_rv1", 32'(redir_valid), 32'd1);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check("ex_idle", 32'(redir_valid), 32'd0);

    // BADV captured only for ADE/ALE
    raise_ex(6'h09, 9'h0, 32'h1C00_0110, 32'h0000_0013);
    check_csr("badv_ale", A_BADV, 32'h13);
    drain("ale");
    raise_ex(6'h0B, 9'h1FF, 32'h1C00_0120, 32'h0000_0055);
    check_csr("badv_keep", A_BADV, 32'h13);
    check_csr("estat_sub", A_ESTAT, 32'h7FCB_0000);
    drain("sys");

    // ertn restores CRMD from PRMD and redirects to ERA
    csr_write(A_PRMD, 32'hFFFF_FFFF, 32'h6);
    csr_write(A_ERA, 32'hFFFF_FFFF, 32'h1C00_0200);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    check("ertn_flush", 32'(flush), 32'd1);
    check("ertn_rpc", redir_pc, 32'h1C00_0200);
    check_csr("ertn_crmd", A_CRMD, 32'h6);
    drain("ertn");

    // Exception beats ertn; redirect held through 3 stalled cycles
    csr_write(A_EENTRY, 32'hFFFF_FFFF, 32'h1234_5678);
    check_csr("eentry_w", A_EENTRY, 32'h1234_5640);
    ertn_flush = 1'b1;
    raise_ex(6'h0B, 9'h0, 32'h1C00_0300, 32'h0);
    ertn_flush = 1'b0;
    check("both_rpc", redir_pc, 32'h1234_5640);
    check_csr("both_era", A_ERA, 32'h1C00_0300);
    check_csr("both_crmd", A_CRMD, 32'h0);
    check_csr("both_prmd", A_PRMD, 32'h6);
    tick();
    wb_ex = 1'b1;
    wb_pc = 32'h0000_BAD0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_rv%0d", i), 32'(redir_valid), 32'd1);
      check($sformatf("stall_pc%0d", i), redir_pc, 32'h1234_5640);
      if (i < 2) tick();
    end
    wb_ex = 1'b0;
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check("stall_idle", 32'(redir_valid), 32'd0);
    check_csr("stall_era", A_ERA, 32'h1C00_0300);

    // CSR write in the exception commit cycle is discarded; read is pre-write
    csr_num = A_CRMD; csr_wmask = 32'h7; csr_wdata = 32'h7; csr_we = 1'b1;
    #1;
    check("prewrite_rd", csr_rvalue, 32'h0);
    raise_ex(6'h0B, 9'h0, 32'h1C00_0400, 32'h0);
    csr_we = 1'b0;
    check_csr("commit_wins", A_CRMD, 32'h0);
    check("commit_rpc", redir_pc, 32'h1234_5640);
    drain("cw");

    // Write masks, read-only fields and has_int
    csr_write(A_ECFG, 32'h0000_FFFF, 32'hFFFF_FFFF);
    check_csr("ecfg_mask", A_ECFG, 32'h0000_1FFF);
    csr_write(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_csr("estat_ro", A_ESTAT, 32'h000B_0003);
    check("int_ie0", 32'(has_int), 32'd0);
    csr_write(A_CRMD, 32'hFFFF_FFFF, 32'h4);
    check("int_sw", 32'(has_int), 32'd1);
    check_csr("unimp", A_UNIMP, 32'h0);
    csr_write(A_ESTAT, 32'h3, 32'h0);
    check("int_clr", 32'(has_int), 32'd0);
    csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h800);

`ifdef TIMER_INT_EN
    // Periodic timer: 0x10 counts to 0, fires, reloads; TICLR clears IS[11]
    csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h13);
    check_csr("tcfg", A_TCFG, 32'h13);
    check_csr("tval_load", A_TVAL, 32'h10);
    repeat (15) tick();
    check_csr("tval_1", A_TVAL, 32'h1);
    check("tmr_int0", 32'(has_int), 32'd0);
    tick();
    check_csr("tval_0", A_TVAL, 32'h0);
    check("tmr_int1", 32'(has_int), 32'd1);
    check_csr("tmr_estat", A_ESTAT, 32'h000B_0800);
    tick();
    check_csr("tval_reload", A_TVAL, 32'h10);
    csr_write(A_TICLR, 32'hFFFF_FFFF, 32'h1);
    check("ticlr_int", 32'(has_int), 32'd0);
    check_csr("ticlr_estat", A_ESTAT, 32'h000B_0000);
    check_csr("ticlr_rd", A_TICLR, 32'h0);
    csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h0);
`else
    // No timer: writes dropped, reads 0, IS[11] never set
    csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h13);
    check_csr("notmr_tcfg", A_TCFG, 32'h0);
    check_csr("notmr_tval", A_TVAL, 32'h0);
    repeat (20) tick();
    check("notmr_int", 32'(has_int), 32'd0);
    check_csr("notmr_estat", A_ESTAT, 32'h000B_0000);
`endif

    // Reset during REDIR abandons the redirect and restores EENTRY
    raise_ex(6'h0B, 9'h0, 32'h1C00_0500, 32'h0);
    tick();
    check("pre_rst_rv", 32'(redir_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("redir_rst_rv", 32'(redir_valid), 32'd0);
    check_csr("redir_rst_eentry", A_EENTRY, 32'h1C00_8000);
    check_csr("redir_rst_crmd", A_CRMD, 32'h0);
    tick();
    check("post_rst_rv", 32'(redir_valid), 32'd0);
    check("post_rst_flush", 32'(flush), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter: EENTRY_RST, default 32'h1C00_8000, reset value of EENTRY.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb_ex  input  1  exception commit from WB, already qualified by WB valid.
REQ-005 wb_ecode  input  6 / wb_esubcode  input  9  exception primary and secondary codes.
REQ-006 wb_pc  input  32 / wb_vaddr  input  32  faulting PC and faulting data address.
REQ-007 ertn_flush  input  1  ertn commit, qualified by WB valid.
REQ-008 csr_num  input  14 / csr_we  input  1 / csr_wmask  input  32 / csr_wdata  input  32  CSR access port.
REQ-009 csr_rvalue  output  32  combinational read of CSR csr_num.
REQ-010 has_int  output  1  enabled interrupt pending.
REQ-011 flush  output  1  pipeline flush strobe.
REQ-012 redir_valid  output  1 / redir_pc  output  32 / redir_ready  input  1  redirect handshake to preIF.

Function
REQ-013 FSM states: IDLE, FLUSH, REDIR.
REQ-014 IDLE: wb_ex or ertn_flush -> latch target into redir_pc, go to FLUSH; wb_ex wins when both are asserted.
REQ-015 FLUSH: flush=1 for exactly one cycle, then go to REDIR.
REQ-016 REDIR: redir_valid=1 with redir_pc held stable; on redir_valid&&redir_ready go to IDLE; redir_valid stays asserted until the handshake completes.
REQ-017 wb_ex and ertn_flush in FLUSH/REDIR: ignored.
REQ-018 Exception accepted in IDLE, same edge:
- PRMD.PPLV[1:0]<=CRMD.PLV; PRMD.PPIE[2]<=CRMD.IE.
- CRMD.PLV<=0; CRMD.IE<=0.
- ERA<=wb_pc.
- ESTAT.Ecode[21:16]<=wb_ecode; ESTAT.EsubCode[30:22]<=wb_esubcode.
- Target = EENTRY.
REQ-019 BADV<=wb_vaddr only when wb_ecode is 0x08 (ADE) or 0x09 (ALE); otherwise BADV is unchanged.
REQ-020 ertn accepted: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PPIE; target = ERA.
REQ-021 CSR map and writable fields:
- CRMD 0x0: PLV[1:0], IE[2].
- PRMD 0x1: PPLV[1:0], PPIE[2].
- ECFG 0x4: LIE[12:0].
- ESTAT 0x5: only IS[1:0] writable by software.
- ERA 0x6: [31:0].
- BADV 0x7: [31:0].
- EENTRY 0xC: [31:6]; bits [5:0] read 0.
REQ-022 CSR write rule: new = (old & ~wmask) | (wdata & wmask), applied to writable bits only; non-writable bits read 0 unless defined above.
REQ-023 csr_we in the cycle an exception or ertn is accepted: write discarded (commit wins).
REQ-024 csr_rvalue returns the pre-write register value; unimplemented csr_num reads 0.
REQ-025 has_int = CRMD.IE && |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational.
REQ-026 Timer CSRs:
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
- TVAL 0x42: read-only.
- TICLR 0x44: reads 0.
REQ-027 TCFG write: TVAL<={InitVal_new,2'b00} on the next edge.
REQ-028 Timer countdown:
- En && TVAL!=0: TVAL<=TVAL-1.
- TVAL==1 && En: set ESTAT.IS[11].
- En && TVAL==0 && Periodic: TVAL<={InitVal,2'b00}.
- En && TVAL==0 && !Periodic: TVAL holds 0.
REQ-029 TICLR write with effective wdata[0]=1: clears IS[11]; a timer set in the same cycle wins.

Reset
REQ-030 On reset:
- FSM=IDLE; flush=0; redir_valid=0; redir_pc=0.
- All CSRs, including TCFG and TVAL, = 0, except EENTRY=EENTRY_RST.
REQ-031 reset in FLUSH or REDIR abandons the redirect; redir_valid=0 from the next cycle.

Configuration
REQ-032 TIMER_INT_EN defined: TCFG, TVAL and TICLR implemented; IS[11] driven by the timer.
REQ-033 TIMER_INT_EN undefined:
- Timer CSRs read 0; writes to them are ignored.
- IS[11] is constant 0.

Verification
REQ-034 CRMD.PLV=3, IE=1; wb_ex, ecode=0x0B, wb_pc=0x1C00_0100:
- flush pulses 1 cycle; redir_pc=0x1C00_8000.
- ERA=0x1C00_0100; PRMD=0x7; CRMD=0.
REQ-035 wb_ex, ecode=0x09, wb_vaddr=0x0000_0013 -> BADV=0x13; repeated with ecode=0x0B -> BADV unchanged.
REQ-036 wb_ex and ertn_flush together; redir_ready=0 for 3 cycles:
- Exception path taken.
- redir_valid held with redir_pc stable; returns to IDLE on the 4th cycle.
REQ-037 TCFG=0x0000_0013 (InitVal=4, Periodic, En); ECFG.LIE[11]=1; CRMD.IE=1:
- IS[11] and has_int set when TVAL goes 1->0.
- TVAL reloads to 0x10.
- TICLR write 1 clears IS[11].
REQ-038 Same-cycle csr_we (CRMD, wmask=0x7, wdata=0x7) and wb_ex -> CRMD=0.
REQ-039 reset asserted in REDIR -> redir_valid=0 next cycle; EENTRY=0x1C00_8000.
